// File: rtl/fft_stage_sched_if.sv
// Control/status bundle between the upstream frame source and the
// FFT stage window scheduler.
interface fft_stage_sched_if #(
    parameter int NUM_STAGES = 3,
    parameter int BW         = 5
);
    logic                       in_valid;
    logic                       flush;
    logic                       clr_err;
    logic [NUM_STAGES-1:0]      stage_en;
    logic [NUM_STAGES*BW-1:0]   stage_beat;
    logic                       frame_done;
    logic [15:0]                frame_cnt;
    logic                       busy;
    logic                       overrun;

    // Upstream side: drives frame valid and control, observes status.
    modport master (
        output in_valid, flush, clr_err,
        input  stage_en, stage_beat, frame_done, frame_cnt, busy, overrun
    );

    // Scheduler side.
    modport slave (
        input  in_valid, flush, clr_err,
        output stage_en, stage_beat, frame_done, frame_cnt, busy, overrun
    );
endinterface

// File: rtl/fft_stage_sched.sv
// Window scheduler for the streaming FFT stage chain: one BEATS-cycle enable
// window per stage, staggered by STAGE_LAT cycles, with a beat index for
// twiddle addressing, frame completion counting, overrun and flush handling.
module fft_stage_sched #(
    parameter int BEATS      = 32,
    parameter int NUM_STAGES = 3,
    parameter int STAGE_LAT  = 4,
    parameter int BW         = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rstn,
    fft_stage_sched_if.slave  bus
);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // Per-stage window state.
    logic [NUM_STAGES-1:0]              active_reg;
    logic [NUM_STAGES-1:0]              active_next;
    logic [NUM_STAGES-1:0][BW-1:0]      beat_reg;
    logic [NUM_STAGES-1:0][BW-1:0]      beat_next;
    logic [NUM_STAGES-1:0]              at_last;
    logic [NUM_STAGES-1:0]              start;

    // Delay line gi carries stage gi's start pulse to stage gi+1. The entry
    // for the last stage has no successor and stays zero.
    logic [NUM_STAGES-1:0][STAGE_LAT-1:0] dly_reg;
    logic [NUM_STAGES-1:0][STAGE_LAT-1:0] dly_next;

    logic        in_valid_prev_reg;
    logic        overrun_reg;
    logic        frame_done_reg;
    logic [15:0] frame_cnt_reg;
    logic        busy_reg;

    logic        overrun_set;
    logic        frame_done_next;
    logic        busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign at_last[gi] = active_reg[gi] && (beat_reg[gi] == LAST_BEAT);

            // Stage 0 accepts a frame when idle or on its last beat (gapless
            // back-to-back); later stages start off the delayed pulse.
            if (gi == 0) begin : g_first
                assign start[gi] = bus.in_valid && (!active_reg[gi] || at_last[gi]);
            end else begin : g_later
                assign start[gi] = dly_reg[gi-1][STAGE_LAT-1];
            end

            assign active_next[gi] = start[gi] || (active_reg[gi] && !at_last[gi]);
            assign beat_next[gi]   = start[gi] ? '0 :
                                     (active_reg[gi] && !at_last[gi]) ? beat_reg[gi] + BW'(1) :
                                     '0;

            if (gi < NUM_STAGES - 1) begin : g_dly
                if (STAGE_LAT == 1) begin : g_one
                    assign dly_next[gi] = start[gi];
                end else begin : g_many
                    assign dly_next[gi] = {dly_reg[gi][STAGE_LAT-2:0], start[gi]};
                end
            end else begin : g_nodly
                assign dly_next[gi] = '0;
            end
        end
    endgenerate

    // Overrun: a fresh frame edge arriving mid-window on stage 0.
    assign overrun_set     = bus.in_valid && !in_valid_prev_reg &&
                             active_reg[0] && !at_last[0];
    assign frame_done_next = at_last[NUM_STAGES-1];
    assign busy_next       = (|active_next) || (|dly_next);

    // State register: reset, flush abort, then normal window sequencing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_reg        <= '0;
            beat_reg          <= '0;
            dly_reg           <= '0;
            in_valid_prev_reg <= 1'b0;
            overrun_reg       <= 1'b0;
            frame_done_reg    <= 1'b0;
            frame_cnt_reg     <= '0;
            busy_reg          <= 1'b0;
        end else begin
            in_valid_prev_reg <= bus.in_valid;
            // Set wins over clear when both happen together.
            overrun_reg       <= overrun_set || (overrun_reg && !bus.clr_err);
            if (bus.flush) begin
                active_reg     <= '0;
                beat_reg       <= '0;
                dly_reg        <= '0;
                frame_done_reg <= 1'b0;
                busy_reg       <= 1'b0;
            end else begin
                active_reg     <= active_next;
                beat_reg       <= beat_next;
                dly_reg        <= dly_next;
                frame_done_reg <= frame_done_next;
                frame_cnt_reg  <= frame_cnt_reg + 16'(frame_done_next);
                busy_reg       <= busy_next;
            end
        end
    end

    assign bus.stage_en   = active_reg;
    assign bus.stage_beat = beat_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.frame_cnt  = frame_cnt_reg;
    assign bus.busy       = busy_reg;
    assign bus.overrun    = overrun_reg;
endmodule

// File: doc/fft_stage_sched.md
# fft_stage_sched

Window scheduler for the streaming FFT butterfly/twiddle stage chain. It turns a per-frame input valid into one BEATS-cycle enable window per stage, staggered by a fixed per-stage latency. Each window carries a beat index that downstream logic uses for twiddle ROM addressing. It replaces per-stage free-running pulse counters with a single controller that also tracks back-to-back frames, overruns, flushes and frame completion.

## Interface
- BEATS, 32: cycles per frame window (16 samples/cycle × 32 = 512 points); power of two, ≥ 2
- NUM_STAGES, 3: number of sequenced butterfly stages
- STAGE_LAT, 4: cycles from stage k window start to stage k+1 window start; 1 ≤ STAGE_LAT ≤ BEATS
- BW, $clog2(BEATS): beat-index width (derived)
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  reset; synchronous, active-low
- in_valid  in  1  upstream frame valid (level)
- flush  in  1  synchronous abort of all windows and pending starts
- clr_err  in  1  clears overrun
- stage_en  out  NUM_STAGES  stage k window active (bit k)
- stage_beat  out  NUM_STAGES*BW  beat index of stage k, bits [k*BW +: BW]; 0 when stage inactive
- frame_done  out  1  one-cycle pulse when the last stage completes a frame
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0
- busy  out  1  any window active or any start pending
- overrun  out  1  sticky; in_valid rising edge while stage 0 busy and not on its last beat

## Operation
- Stage 0 start condition, sampled at cycle T: in_valid=1 AND (stage 0 idle OR stage 0 on beat BEATS-1).
  - Window runs T+1 … T+BEATS with stage_beat[0] = 0 … BEATS-1.
  - A start at the last beat gives gapless back-to-back windows.
- in_valid high in any other cycle of an active stage-0 window is ignored (streaming data), except as below.
- Overrun: a 0→1 edge on in_valid (previous sampled value registered internally) while stage 0 is active at beat < BEATS-1:
  - Sets overrun; no restart and no extension of the window.
- Start pulses propagate through a STAGE_LAT-deep delay line per stage boundary. Stage k starts STAGE_LAT cycles after stage k-1.
- Each stage has its own beat counter and active flag. A start while active at beat BEATS-1 reloads the counter to 0 with no gap. Windows cannot otherwise collide.
- Beat counter after BEATS-1 with no new start: stage goes inactive and stage_beat reads 0.
- frame_done: pulses the cycle after stage NUM_STAGES-1 shows beat BEATS-1. frame_cnt increments in that same cycle.
- flush=1: next cycle all stage_en=0, all beats=0, delay lines cleared, busy=0, no frame_done.
  - frame_cnt and overrun are held.
  - flush has priority over a start in the same cycle.
- clr_err and overrun-set in the same cycle: set wins.
- busy = OR of all active flags and all delay-line bits.

## Timing
- Reset (rstn=0 at an edge) clears everything: stage_en=0, stage_beat=0, frame_done=0, frame_cnt=0, busy=0, overrun=0, delay lines and in_valid history=0.
- Reset mid-frame drops the frame with no frame_done.
- All outputs are registered.
- Latency from in_valid sampled high at T (idle):
  - stage_en[0]=1 at T+1.
  - stage_en[k] rises at T+1+k·STAGE_LAT.
  - Last-stage final beat at T+(NUM_STAGES-1)·STAGE_LAT+BEATS.
  - frame_done and frame_cnt update one cycle later.
- Defaults give stage_en[2] over T+9…T+40, frame_done at T+41.
- Continuous in_valid: one frame per BEATS cycles, frame_done every BEATS cycles in steady state.
- busy rises at T+1 and falls the cycle frame_done is asserted (when no further frames are pending).

## Test plan
- Single frame, defaults: in_valid high for 32 cycles from T.
  - stage_en[0] over T+1…T+32 and stage_en[1] over T+5…T+36, beats 0…31.
  - frame_done at T+41 only; frame_cnt=1; overrun=0.
- Back-to-back: in_valid held high for 96 cycles.
  - Gapless stage_en on all stages, beat 31→0 wrap with no idle cycle.
  - Three frame_done pulses at T+41, T+73, T+105.
- Overrun: in_valid 1 at T, 0 at T+10, 1 at T+11.
  - overrun=1 from T+12; stage 0 window still ends at T+32.
  - clr_err at T+50 → overrun=0 at T+51.
- Flush mid-frame: start at T, flush at T+20.
  - All stage_en=0 and busy=0 at T+21, no frame_done.
  - A new start at T+25 behaves as from idle.
- Reset mid-frame: rstn low at T+15 for 2 cycles → all outputs 0, frame_cnt=0; no residual window after release.
- Wrap: preload via 65 536 frames with STAGE_LAT=1, BEATS=2 build → frame_cnt wraps 0xFFFF→0x0000.
